// File: rtl/mem_responder_pkg.sv
// Shared types and encodings for the memory responder: address type, f3 size codes,
// responder FSM states and request-legality helpers.
package mem_responder_pkg;

    typedef logic [31:0] mem_addr_t;

    // f3 size encodings, identical to what the core datapath emits
    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_W  = 3'd2;
    localparam logic [2:0] MEM_BU = 3'd4;
    localparam logic [2:0] MEM_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } resp_state_t;

    function automatic logic is_reserved(input logic [2:0] size);
        return (size == 3'd3) || (size == 3'd6) || (size == 3'd7);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] addr, input logic [2:0] size);
        case (size)
            MEM_H, MEM_HU: return addr[0];
            MEM_W:         return addr != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core memory port (master) and the responder (slave).
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    mem_addr_t   req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores (replicated data + byte enables) and lane extraction
// with sign/zero extension for loads.
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic [31:0] wdata,
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] st_data,
    output logic [3:0]  be,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Bring the addressed lane down to bit 0 so extraction is lane-independent
    assign shifted = ld_word >> {lane, 3'b000};

    always_comb begin
        st_data = '0;
        be      = '0;
        ld_data = '0;
        case (size)
            MEM_B, MEM_BU: begin
                st_data = {4{wdata[7:0]}};
                be      = 4'b0001 << lane;
                ld_data = (size == MEM_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'b0, shifted[7:0]};
            end
            MEM_H, MEM_HU: begin
                st_data = {2{wdata[15:0]}};
                be      = 4'b0011 << lane;
                ld_data = (size == MEM_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                          : {16'b0, shifted[15:0]};
            end
            MEM_W: begin
                st_data = wdata;
                be      = 4'b1111;
                ld_data = ld_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder backed by a word-wide synchronous SRAM with byte
// enables; rejects misaligned, reserved-size and out-of-range requests.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter mem_addr_t   BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter string       INIT_FILE   = ""
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

    resp_state_t      state;
    logic [3:0]       cnt;
    logic             we_r, fault_r;
    logic [2:0]       size_r;
    logic [1:0]       lane_r;
    logic [IDX_W-1:0] idx_r;
    logic [31:0]      wdata_r, rd_word, st_data, ld_data;
    logic [3:0]       be;
    mem_addr_t        off;
    logic             req_fault;

    logic [31:0] mem [DEPTH];

    // Unsigned offset: addresses below BASE_ADDR wrap high and land in the range fault
    assign off       = bus.req_addr - BASE_ADDR;
    assign req_fault = is_reserved(bus.req_size)
                    || is_misaligned(bus.req_addr[1:0], bus.req_size)
                    || ({1'b0, off} >= MEM_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            fault_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_r    <= bus.req_we;
                    size_r  <= bus.req_size;
                    lane_r  <= bus.req_addr[1:0];
                    idx_r   <= off[IDX_W+1:2];
                    wdata_r <= bus.req_wdata;
                    fault_r <= req_fault;
                    if (req_fault) state <= RESP;
                    else if (WAIT_CYCLES != 0) begin
                        state <= WAIT;
                        cnt   <= 4'(WAIT_CYCLES - 1);
                    end else state <= ACCESS;
                end
                WAIT:    if (cnt == '0) state <= ACCESS; else cnt <= cnt - 4'd1;
                ACCESS:  state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Write gated by rst so a store caught by reset in ACCESS never commits
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS) begin
            if (we_r) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[idx_r][8*b +: 8] <= st_data[8*b +: 8];
            end else begin
                rd_word <= mem[idx_r];
            end
        end
    end

    mem_lane_align u_align (
        .wdata   (wdata_r),
        .size    (size_r),
        .lane    (lane_r),
        .st_data (st_data),
        .be      (be),
        .ld_word (rd_word),
        .ld_data (ld_data)
    );

    assign bus.req_ready = !rst && state == IDLE;
    assign bus.rsp_valid = !rst && state == RESP;
    assign bus.rsp_fault = !rst && state == RESP && fault_r;
    assign bus.rsp_rdata = rst ? RESET_VEC
                         : (state == RESP && !fault_r && !we_r) ? ld_data : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a zero-wait instance and a three-wait-state instance
// share one request driver; expected values are hand-computed constants.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if m0();
    mem_responder_if m1();

    logic        t_sel = 1'b0, t_valid = 1'b0, t_we = 1'b0;
    logic [31:0] t_addr = '0, t_wdata = '0;
    logic [2:0]  t_size = '0;

    assign m0.req_valid = t_valid & ~t_sel;
    assign m1.req_valid = t_valid &  t_sel;
    assign m0.req_we    = t_we;    assign m1.req_we    = t_we;
    assign m0.req_addr  = t_addr;  assign m1.req_addr  = t_addr;
    assign m0.req_size  = t_size;  assign m1.req_size  = t_size;
    assign m0.req_wdata = t_wdata; assign m1.req_wdata = t_wdata;

    mem_responder #(.RESET_VEC(32'h8000_0000)) dut0 (.clk(clk), .rst(rst), .bus(m0));
    mem_responder #(.WAIT_CYCLES(3))           dut1 (.clk(clk), .rst(rst), .bus(m1));

    logic        o_ready, o_valid, o_fault;
    logic [31:0] o_rdata;
    assign o_ready = t_sel ? m1.req_ready : m0.req_ready;
    assign o_valid = t_sel ? m1.rsp_valid : m0.rsp_valid;
    assign o_fault = t_sel ? m1.rsp_fault : m0.rsp_fault;
    assign o_rdata = t_sel ? m1.rsp_rdata : m0.rsp_rdata;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One request; reports the data/fault of the response strobe, the number of
    // negedges from the accepting edge to it, and how often ready was seen high meanwhile.
    task automatic do_req(input logic sel, input logic we, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic fault,
                          output int lat, output int rdy_hi);
        @(negedge clk);
        t_sel = sel; t_we = we; t_addr = addr; t_size = size; t_wdata = wdata;
        t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        lat = 0; rdy_hi = 0; rdata = 32'hx; fault = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o_ready) rdy_hi++;
            if (o_valid) begin
                lat = k; rdata = o_rdata; fault = o_fault;
                break;
            end
        end
    endtask

    task automatic req_chk(input string tag, input logic sel, input logic we,
                           input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_fault, input int exp_lat);
        logic [31:0] rd;
        logic        flt;
        int          lat, rh;
        do_req(sel, we, addr, size, wdata, rd, flt, lat, rh);
        chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rd, exp_rdata);
        chk({tag, "_fault"}, {31'b0, flt}, {31'b0, exp_fault});
        chk({tag, "_busy"},  32'(rh), 32'd0);
    endtask

    initial begin
        // Reset: vector on rdata, no ready, no response
        repeat (3) @(negedge clk);
        chk("rst_rdata", m0.rsp_rdata, 32'h8000_0000);
        chk("rst_ready", {31'b0, m0.req_ready}, 32'd0);
        chk("rst_valid", {31'b0, m0.rsp_valid}, 32'd0);
        chk("rst_fault", {31'b0, m0.rsp_fault}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'b0, m0.req_ready}, 32'd1);
        chk("idle_rdata", m0.rsp_rdata, 32'h0);

        // Word store then lane loads with extension
        req_chk("sw10",  0, 1, 32'h10, MEM_W,  32'hDEAD_BEEF, 32'h0, 0, 2);
        req_chk("lb13",  0, 0, 32'h13, MEM_B,  32'h0, 32'hFFFF_FFDE, 0, 2);
        req_chk("lbu13", 0, 0, 32'h13, MEM_BU, 32'h0, 32'h0000_00DE, 0, 2);
        req_chk("lh12",  0, 0, 32'h12, MEM_H,  32'h0, 32'hFFFF_DEAD, 0, 2);
        req_chk("lhu10", 0, 0, 32'h10, MEM_HU, 32'h0, 32'h0000_BEEF, 0, 2);
        req_chk("lb10",  0, 0, 32'h10, MEM_B,  32'h0, 32'hFFFF_FFEF, 0, 2);

        // Byte and halfword stores only touch their lanes
        req_chk("sw20",  0, 1, 32'h20, MEM_W,  32'h0, 32'h0, 0, 2);
        req_chk("sb21",  0, 1, 32'h21, MEM_B,  32'hFFFF_FF5A, 32'h0, 0, 2);
        req_chk("lw20a", 0, 0, 32'h20, MEM_W,  32'h0, 32'h0000_5A00, 0, 2);
        req_chk("sh22",  0, 1, 32'h22, MEM_H,  32'hABCD_1234, 32'h0, 0, 2);
        req_chk("lw20b", 0, 0, 32'h20, MEM_W,  32'h0, 32'h1234_5A00, 0, 2);

        // Faults: one cycle, zero data, memory untouched
        req_chk("sw0",   0, 1, 32'h0,    MEM_W,  32'h0BAD_F00D, 32'h0, 0, 2);
        req_chk("f_lw2", 0, 0, 32'h2,    MEM_W,  32'h0, 32'h0, 1, 1);
        req_chk("f_lh1", 0, 0, 32'h1,    MEM_H,  32'h0, 32'h0, 1, 1);
        req_chk("f_sz3", 0, 0, 32'h0,    3'd3,   32'h0, 32'h0, 1, 1);
        req_chk("f_sz7", 0, 1, 32'h0,    3'd7,   32'hFFFF_FFFF, 32'h0, 1, 1);
        req_chk("f_oor", 0, 0, 32'h1000, MEM_W,  32'h0, 32'h0, 1, 1);
        req_chk("f_sw",  0, 1, 32'h12,   MEM_W,  32'h1111_1111, 32'h0, 1, 1);
        req_chk("f_sh",  0, 1, 32'h11,   MEM_HU, 32'h2222_2222, 32'h0, 1, 1);
        req_chk("f_sb",  0, 1, 32'h1000, MEM_B,  32'hEE, 32'h0, 1, 1);
        req_chk("lw10",  0, 0, 32'h10,   MEM_W,  32'h0, 32'hDEAD_BEEF, 0, 2);
        req_chk("lw0",   0, 0, 32'h0,    MEM_W,  32'h0, 32'h0BAD_F00D, 0, 2);

        // Three wait states: response at accept+5, ready low throughout
        req_chk("w_sw",  1, 1, 32'h10, MEM_W, 32'hA5A5_0001, 32'h0, 0, 5);
        req_chk("w_lw",  1, 0, 32'h10, MEM_W, 32'h0, 32'hA5A5_0001, 0, 5);
        req_chk("w_flt", 1, 0, 32'h3,  MEM_H, 32'h0, 32'h0, 1, 1);
        @(negedge clk);
        chk("w_ready_after", {31'b0, m1.req_ready}, 32'd1);

        // Reset during the ACCESS cycle of a store drops it silently
        req_chk("a_sw_old", 0, 1, 32'h40, MEM_W, 32'h1234_5678, 32'h0, 0, 2);
        @(negedge clk);
        t_sel = 1'b0; t_we = 1'b1; t_addr = 32'h40; t_size = MEM_W;
        t_wdata = 32'hCAFE_F00D; t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("a_rst_rdata", m0.rsp_rdata, 32'h8000_0000);
        chk("a_rst_valid", {31'b0, m0.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("a_rst_valid2", {31'b0, m0.rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("a_post_valid", {31'b0, m0.rsp_valid}, 32'd0);
        chk("a_post_ready", {31'b0, m0.req_ready}, 32'd1);
        req_chk("a_lw_old", 0, 0, 32'h40, MEM_W, 32'h0, 32'h1234_5678, 0, 2);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
